// File: rtl/usb_buf_pkg.sv
// Shared definitions for the USB endpoint buffer readers/writers (OUT drain, IN fill).
// Geometry constants and the OUT-reader state encoding live here so both sides agree.
package usb_buf_pkg;

    localparam int USB_BUF_ADDR_W  = 9;
    localparam int USB_BUF_LEN_W   = 10;
    localparam int USB_MAX_PKT_LEN = 512;
    localparam int USB_SKID_DEPTH  = 2;

    typedef enum logic [1:0] {
        OUT_RD_IDLE = 2'd0,
        OUT_RD_READ = 2'd1,
        OUT_RD_ARM  = 2'd2,
        OUT_RD_HOLD = 2'd3
    } out_rd_state_e;

endpackage

// File: rtl/usb_skid_fifo.sv
// 2-entry 8-bit FIFO decoupling the 1-cycle RAM read from the byte stream.
// Zero-latency head (valid/q combinational from storage); push while full is dropped, so callers credit-limit.
module usb_skid_fifo (
    input  logic       phy_ulpi_clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] data,
    input  logic       pop,
    output logic       valid,
    output logic [7:0] q,
    output logic [1:0] count
);

    logic [7:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop && (count != 2'd0);
    // A full FIFO can still take a push in the same cycle it pops.
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= 8'd0;
            mem[1] <= 8'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign valid = (count != 2'd0);
    assign q     = mem[rd_ptr];

endmodule

// File: rtl/usb_out_buf_reader.sv
// Drains a received OUT packet from the buffer RAM onto a byte stream, then re-arms the buffer.
// First byte 3 cycles after hasdata, then 1 byte/cycle; m_ready low stalls with at most 2 reads outstanding.
module usb_out_buf_reader
    import usb_buf_pkg::*;
#(
    parameter int ADDR_W  = USB_BUF_ADDR_W,
    parameter int LEN_W   = USB_BUF_LEN_W,
    parameter int MAX_LEN = USB_MAX_PKT_LEN
) (
    input  logic              phy_ulpi_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              buf_out_hasdata,
    input  logic [LEN_W-1:0]  buf_out_len,
    output logic [ADDR_W-1:0] buf_out_addr,
    input  logic [7:0]        buf_out_q,
    output logic              buf_out_arm,
    input  logic              buf_out_arm_ack,
    output logic [7:0]        m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              zlp,
    output logic              len_err,
    output logic [15:0]       pkt_cnt
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    out_rd_state_e state;
    out_rd_state_e state_nxt;

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] rd_cnt;
    logic [LEN_W-1:0] out_cnt;
    logic             rd_inflight;

    logic             start;
    logic             over_len;
    logic [LEN_W-1:0] len_eff;
    logic             rd_issue;
    logic [2:0]       occ_after;
    logic             last_acc;

    logic             fifo_valid;
    logic [7:0]       fifo_q;
    logic [1:0]       fifo_count;
    logic             fifo_pop;

    assign start    = (state == OUT_RD_IDLE) && enable && buf_out_hasdata;
    assign over_len = (buf_out_len > MAX_LEN_L);
    assign len_eff  = over_len ? MAX_LEN_L : buf_out_len;

    assign fifo_pop = fifo_valid && m_ready;
    assign last_acc = fifo_pop && m_last;

    // Credit check counts the byte leaving this cycle so a full-rate stream never bubbles.
    assign occ_after = {1'b0, fifo_count} + {2'b00, rd_inflight} - {2'b00, fifo_pop};
    assign rd_issue  = (state == OUT_RD_READ) && (rd_cnt < len_q) && (occ_after < 3'd2);

    assign buf_out_addr = rd_cnt[ADDR_W-1:0];
    assign m_valid      = fifo_valid;
    assign m_data       = fifo_q;

    usb_skid_fifo u_fifo (
        .phy_ulpi_clk (phy_ulpi_clk),
        .reset_n      (reset_n),
        .push         (rd_inflight),
        .data         (buf_out_q),
        .pop          (fifo_pop),
        .valid        (fifo_valid),
        .q            (fifo_q),
        .count        (fifo_count)
    );

    always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= OUT_RD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            OUT_RD_IDLE: begin
                if (start) begin
                    state_nxt = (len_eff == '0) ? OUT_RD_ARM : OUT_RD_READ;
                end
            end
            OUT_RD_READ: begin
                if (last_acc) begin
                    state_nxt = OUT_RD_ARM;
                end
            end
            OUT_RD_ARM: begin
                if (buf_out_arm_ack) begin
                    state_nxt = OUT_RD_HOLD;
                end
            end
            // One dead cycle lets the core drop hasdata before IDLE looks at it again.
            OUT_RD_HOLD: begin
                state_nxt = OUT_RD_IDLE;
            end
            default: begin
                state_nxt = OUT_RD_IDLE;
            end
        endcase
    end

    always_comb begin
        buf_out_arm = (state == OUT_RD_ARM);
        zlp         = start && (len_eff == '0);
        len_err     = start && over_len;
        m_last      = fifo_valid && (out_cnt == (len_q - 1'b1));
    end

    always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q       <= '0;
            rd_cnt      <= '0;
            out_cnt     <= '0;
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= rd_issue;
            if (start) begin
                len_q   <= len_eff;
                rd_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (rd_issue) begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
                if (fifo_pop) begin
                    out_cnt <= out_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt <= 16'd0;
        end else if ((state == OUT_RD_ARM) && buf_out_arm_ack) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_usb_out_buf_reader.sv
// Directed bench for usb_out_buf_reader: RAM model, arm-ack driver, negedge stream monitor.
module tb_usb_out_buf_reader;

    logic        phy_ulpi_clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        buf_out_hasdata;
    logic [9:0]  buf_out_len;
    logic [8:0]  buf_out_addr;
    logic [7:0]  buf_out_q = 8'd0;
    logic        buf_out_arm;
    logic        buf_out_arm_ack;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic        zlp;
    logic        len_err;
    logic [15:0] pkt_cnt;

    logic [7:0]  ram [0:511];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // monitor-owned state
    logic [7:0] rx_d [$];
    logic       rx_l [$];
    int         rx_t [$];
    int         acc_total   = 0;
    int         valid_total = 0;
    int         zlp_total   = 0;
    int         lerr_total  = 0;
    int         arm_total   = 0;
    int         stab_err    = 0;
    int         max_out     = 0;
    logic       stall_v     = 1'b0;
    logic [7:0] stall_d     = 8'd0;

    // test-owned state
    bit oc_en    = 1'b0;
    int acc_base = 0;
    int t0, t_arm, arm_low;
    bit got_arm, arm_after_ack;
    int b_acc, b_valid, b_zlp, b_lerr, b_arm, b_stab;

    usb_out_buf_reader dut (
        .phy_ulpi_clk    (phy_ulpi_clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .buf_out_hasdata (buf_out_hasdata),
        .buf_out_len     (buf_out_len),
        .buf_out_addr    (buf_out_addr),
        .buf_out_q       (buf_out_q),
        .buf_out_arm     (buf_out_arm),
        .buf_out_arm_ack (buf_out_arm_ack),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_last          (m_last),
        .m_ready         (m_ready),
        .zlp             (zlp),
        .len_err         (len_err),
        .pkt_cnt         (pkt_cnt)
    );

    always #5 phy_ulpi_clk = ~phy_ulpi_clk;

    always @(posedge phy_ulpi_clk) begin
        cyc       <= cyc + 1;
        buf_out_q <= ram[buf_out_addr];
    end

    always @(negedge phy_ulpi_clk) begin
        if (oc_en) begin
            int cur;
            cur = int'(buf_out_addr) - (acc_total - acc_base);
            if (cur > max_out) max_out = cur;
        end
        if (stall_v && (!m_valid || m_data !== stall_d)) stab_err++;
        stall_v = m_valid && !m_ready;
        stall_d = m_data;
        if (m_valid) valid_total++;
        if (m_valid && m_ready) begin
            rx_d.push_back(m_data);
            rx_l.push_back(m_last);
            rx_t.push_back(cyc);
            acc_total++;
        end
        if (zlp) zlp_total++;
        if (len_err) lerr_total++;
        if (buf_out_arm) arm_total++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + (i >> 8) * 91 + 5) & 255);
    endfunction

    task automatic snap();
        b_acc   = acc_total;
        b_valid = valid_total;
        b_zlp   = zlp_total;
        b_lerr  = lerr_total;
        b_arm   = arm_total;
        b_stab  = stab_err;
    endtask

    // Drive one packet through to the end of the arm handshake.
    task automatic run_pkt(input int len, input int ack_dly, input bit hold_hd,
                           input int rdy_mode, input int chg_len, input bit dis_mid);
        @(posedge phy_ulpi_clk); #1;
        snap();
        acc_base        = acc_total;
        buf_out_len     = 10'(len);
        buf_out_hasdata = 1'b1;
        m_ready         = 1'b1;
        t0              = cyc;
        got_arm         = 1'b0;
        for (int k = 0; k < 1200; k++) begin
            @(posedge phy_ulpi_clk); #1;
            if (k == 0) begin
                oc_en = (rdy_mode != 0);
                if (chg_len >= 0) buf_out_len = 10'(chg_len);
                if (dis_mid) enable = 1'b0;
            end
            if (buf_out_arm) begin
                got_arm = 1'b1;
                break;
            end
            m_ready = (rdy_mode == 0) ? 1'b1 : (((k + 1) % 4 == 0) || ((k + 1) % 4 == 3));
        end
        oc_en   = 1'b0;
        m_ready = 1'b1;
        chk("arm_seen", 32'(got_arm), 1);
        t_arm   = cyc;
        arm_low = 0;
        for (int k = 0; k < ack_dly; k++) begin
            if (!buf_out_arm) arm_low++;
            @(posedge phy_ulpi_clk); #1;
        end
        if (!buf_out_arm) arm_low++;
        buf_out_arm_ack = 1'b1;
        @(posedge phy_ulpi_clk); #1;
        buf_out_arm_ack = 1'b0;
        arm_after_ack   = buf_out_arm;
        if (hold_hd) begin
            @(posedge phy_ulpi_clk); #1;
        end
        buf_out_hasdata = 1'b0;
    endtask

    task automatic check_stream(input string tag, input int n);
        int got, derr, lerr;
        got  = acc_total - b_acc;
        derr = 0;
        lerr = 0;
        for (int j = 0; j < got && j < n; j++) begin
            if (rx_d[b_acc + j] !== ram[j]) derr++;
            if (rx_l[b_acc + j] !== (j == n - 1)) lerr++;
        end
        chk({tag, "_count"}, 32'(got), 32'(n));
        chk({tag, "_data_err"}, 32'(derr), 0);
        chk({tag, "_last_err"}, 32'(lerr), 0);
    endtask

    initial begin
        reset_n         = 1'b0;
        enable          = 1'b1;
        buf_out_hasdata = 1'b0;
        buf_out_len     = 10'd0;
        buf_out_arm_ack = 1'b0;
        m_ready         = 1'b1;
        for (int i = 0; i < 512; i++) ram[i] = pat(i);
        for (int i = 0; i < 4; i++) ram[i] = 8'(8'hA0 + i);

        repeat (3) @(posedge phy_ulpi_clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_arm", 32'(buf_out_arm), 0);
        chk("rst_addr", 32'(buf_out_addr), 0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
        chk("rst_zlp_lenerr", {30'd0, zlp, len_err}, 0);
        reset_n = 1'b1;

        // 4-byte packet, full rate
        run_pkt(4, 0, 1'b0, 0, -1, 1'b0);
        for (int j = 0; j < 4; j++) begin
            if (acc_total - b_acc > j) begin
                chk("t1_data", 32'(rx_d[b_acc + j]), 32'(8'hA0 + j));
                chk("t1_last", 32'(rx_l[b_acc + j]), 32'(j == 3));
            end
        end
        chk("t1_count", 32'(acc_total - b_acc), 4);
        if (acc_total - b_acc >= 4) begin
            chk("t1_first_cyc", 32'(rx_t[b_acc] - t0), 3);
            chk("t1_last_cyc", 32'(rx_t[b_acc + 3] - t0), 6);
        end
        chk("t1_arm_cyc", 32'(t_arm - t0), 7);
        chk("t1_arm_drop", 32'(arm_after_ack), 0);
        chk("t1_pkt_cnt", 32'(pkt_cnt), 1);

        for (int i = 0; i < 4; i++) ram[i] = pat(i);

        // 8-byte packet, m_ready 1,0,0,1..., length changes after latch
        run_pkt(8, 0, 1'b0, 1, 3, 1'b0);
        check_stream("t2", 8);
        chk("t2_stable", 32'(stab_err - b_stab), 0);
        chk("t2_max_outstanding", 32'(max_out), 2);
        chk("t2_pkt_cnt", 32'(pkt_cnt), 2);

        // zero-length packet
        run_pkt(0, 0, 1'b0, 0, -1, 1'b0);
        chk("t3_zlp", 32'(zlp_total - b_zlp), 1);
        chk("t3_no_valid", 32'(valid_total - b_valid), 0);
        chk("t3_arm_cyc", 32'(t_arm - t0), 1);
        chk("t3_pkt_cnt", 32'(pkt_cnt), 3);

        // maximum length
        run_pkt(512, 0, 1'b0, 0, -1, 1'b0);
        check_stream("t4", 512);
        chk("t4_len_err", 32'(lerr_total - b_lerr), 0);
        if (acc_total - b_acc >= 512) chk("t4_last_cyc", 32'(rx_t[b_acc + 511] - t0), 514);
        chk("t4_pkt_cnt", 32'(pkt_cnt), 4);

        // over-length clamps to 512
        run_pkt(700, 0, 1'b0, 0, -1, 1'b0);
        check_stream("t5", 512);
        chk("t5_len_err", 32'(lerr_total - b_lerr), 1);

        // delayed ack with hasdata lingering through the ack and HOLD cycles
        run_pkt(2, 5, 1'b1, 0, -1, 1'b0);
        chk("t6_arm_held", 32'(arm_low), 0);
        chk("t6_arm_drop", 32'(arm_after_ack), 0);
        snap();
        repeat (6) @(posedge phy_ulpi_clk);
        #1;
        chk("t6_no_reread", 32'(valid_total - b_valid), 0);
        chk("t6_no_rearm", 32'(arm_total - b_arm), 0);
        run_pkt(3, 0, 1'b0, 0, -1, 1'b0);
        check_stream("t6b", 3);
        chk("t6_pkt_cnt", 32'(pkt_cnt), 7);

        // enable drops mid-packet: packet completes, new starts blocked
        run_pkt(4, 0, 1'b0, 0, -1, 1'b1);
        check_stream("t7", 4);
        chk("t7_pkt_cnt", 32'(pkt_cnt), 8);
        snap();
        buf_out_len     = 10'd2;
        buf_out_hasdata = 1'b1;
        repeat (6) @(posedge phy_ulpi_clk);
        #1;
        chk("t7_blocked_valid", 32'(valid_total - b_valid), 0);
        chk("t7_blocked_arm", 32'(arm_total - b_arm), 0);
        buf_out_hasdata = 1'b0;
        enable          = 1'b1;

        // reset after 3 of 10 bytes
        @(posedge phy_ulpi_clk); #1;
        snap();
        buf_out_len     = 10'd10;
        buf_out_hasdata = 1'b1;
        got_arm         = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge phy_ulpi_clk); #1;
            if (acc_total - b_acc >= 3) begin
                got_arm = 1'b1;
                break;
            end
        end
        chk("t8_reach3", 32'(got_arm), 1);
        chk("t8_pre_valid", 32'(m_valid), 1);
        reset_n         = 1'b0;
        buf_out_hasdata = 1'b0;
        #1;
        chk("t8_valid", 32'(m_valid), 0);
        chk("t8_last_data", {23'd0, m_last, m_data}, 0);
        chk("t8_addr", 32'(buf_out_addr), 0);
        chk("t8_pkt_cnt", 32'(pkt_cnt), 0);
        snap();
        repeat (3) @(posedge phy_ulpi_clk);
        #1;
        reset_n = 1'b1;
        chk("t8_no_arm", 32'(arm_total - b_arm), 0);
        run_pkt(5, 0, 1'b0, 0, -1, 1'b0);
        check_stream("t8b", 5);
        chk("t8b_pkt_cnt", 32'(pkt_cnt), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
